// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer result queues with round-robin grant
// and a registered broadcast of {tag, value} to the ROB and reservation stations.
module cdb_arbiter #(
    parameter int NSRC   = 3,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NSRC-1:0]          req_valid,
    input  logic [NSRC*TAG_W-1:0]    req_tag,
    input  logic [NSRC*DATA_W-1:0]   req_data,
    output logic [NSRC-1:0]          req_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [1:0]               cdb_src,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [1:0]    LAST = 2'(NSRC - 1);
    localparam logic [2:0]    NS3  = 3'(NSRC);

    logic [TAG_W-1:0]  mem_tag  [NSRC][DEPTH];
    logic [DATA_W-1:0] mem_data [NSRC][DEPTH];

    logic [PW-1:0] wr_ptr [NSRC];
    logic [PW-1:0] rd_ptr [NSRC];
    logic [CW-1:0] count  [NSRC];

    logic [1:0] rr_ptr;

    logic [NSRC-1:0] nonempty;
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] pop;

    logic       found;
    logic [1:0] win;
    logic [2:0] cand;

    logic [TAG_W-1:0]  head_tag;
    logic [DATA_W-1:0] head_data;

    // Queue status taken from registered counts only, so ready never
    // depends on this cycle's valid or on this cycle's pop.
    always_comb begin
        nonempty  = '0;
        req_ready = '0;
        push      = '0;
        for (int i = 0; i < NSRC; i++) begin
            nonempty[i]  = (count[i] != '0);
            req_ready[i] = (count[i] < FULL);
            push[i]      = req_valid[i] & req_ready[i] & ~flush;
        end
        busy = |nonempty;
    end

    // Round-robin search starting at rr_ptr; first non-empty queue wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NSRC; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= NS3) begin
                cand = cand - NS3;
            end
            if (!found && nonempty[cand[1:0]]) begin
                found = 1'b1;
                win   = cand[1:0];
            end
        end
        pop = '0;
        if (found && !flush) begin
            pop[win] = 1'b1;
        end
        head_tag  = mem_tag[win][rd_ptr[win]];
        head_data = mem_data[win][rd_ptr[win]];
    end

    // Queue storage; contents need no reset because counts gate every read.
    always_ff @(posedge clk1) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push[i]) begin
                mem_tag[i][wr_ptr[i]]  <= req_tag[i*TAG_W +: TAG_W];
                mem_data[i][wr_ptr[i]] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointers, occupancy and round-robin pointer; flush wins over push/pop.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr <= '0;
        end else if (flush) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                unique case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
            if (found) begin
                rr_ptr <= (win == LAST) ? 2'd0 : win + 2'd1;
            end
        end
    end

    // Registered broadcast; payload holds its last value when idle.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (found) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= head_tag;
            cdb_data  <= head_data;
            cdb_src   <= win;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdb_arbiter;

    localparam int NSRC   = 3;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  req_valid;
    logic [8:0]  req_tag;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic [1:0]  cdb_src;
    logic        busy;

    cdb_arbiter #(
        .NSRC(NSRC), .TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk1(clk1), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_src(cdb_src), .busy(busy)
    );

    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic [2:0]  tag;
        logic [15:0] data;
    } ent_t;

    ent_t        mq [NSRC][$];
    logic        ev;
    logic [2:0]  et;
    logic [15:0] ed;
    logic [1:0]  es;
    int          rr;

    int   total = 0;
    int   bad   = 0;
    logic chk_on  = 1'b0;
    logic rec_mul = 1'b0;
    bit   seen_dead = 1'b0;
    logic [2:0] mul_seen [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic m_busy();
        logic b = 1'b0;
        for (int s = 0; s < NSRC; s++) if (mq[s].size() > 0) b = 1'b1;
        return b;
    endfunction

    function automatic logic [2:0] m_ready();
        logic [2:0] r = '0;
        for (int s = 0; s < NSRC; s++) r[s] = (mq[s].size() < DEPTH);
        return r;
    endfunction

    // Reference model: FIFO per source, round-robin pick, one-cycle broadcast.
    always @(posedge clk1 or posedge rst) begin : model
        int         w;
        logic [2:0] rdy;
        ent_t       e;
        if (rst) begin
            for (int s = 0; s < NSRC; s++) mq[s].delete();
            rr <= 0;
            ev <= 1'b0;
            et <= '0;
            ed <= '0;
            es <= '0;
        end else if (flush) begin
            for (int s = 0; s < NSRC; s++) mq[s].delete();
            rr <= 0;
            ev <= 1'b0;
        end else begin
            rdy = m_ready();
            w = -1;
            for (int k = 0; k < NSRC; k++)
                if (w < 0 && mq[(rr + k) % NSRC].size() > 0)
                    w = (rr + k) % NSRC;
            if (w >= 0) begin
                e = mq[w].pop_front();
                ev <= 1'b1;
                et <= e.tag;
                ed <= e.data;
                es <= 2'(w);
                rr <= (w + 1) % NSRC;
            end else begin
                ev <= 1'b0;
            end
            for (int s = 0; s < NSRC; s++) begin
                if (req_valid[s] && rdy[s]) begin
                    e.tag  = req_tag[s*3 +: 3];
                    e.data = req_data[s*16 +: 16];
                    mq[s].push_back(e);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk1) begin
        if (chk_on && !rst) begin
            chk("cdb_valid", 32'(cdb_valid), 32'(ev));
            chk("cdb_tag", 32'(cdb_tag), 32'(et));
            chk("cdb_data", 32'(cdb_data), 32'(ed));
            chk("cdb_src", 32'(cdb_src), 32'(es));
            chk("busy", 32'(busy), 32'(m_busy()));
            chk("req_ready", 32'(req_ready), 32'(m_ready()));
            if (cdb_valid && cdb_data == 16'hDEAD) seen_dead <= 1'b1;
            if (rec_mul && cdb_valid && cdb_src == 2'd1)
                mul_seen.push_back(cdb_tag);
        end
    end

    task automatic drive(input int s, input logic [2:0] t,
                         input logic [15:0] d);
        req_valid[s]        = 1'b1;
        req_tag[s*3 +: 3]   = t;
        req_data[s*16 +: 16] = d;
    endtask

    initial begin
        int   tg [3];
        int   dt [3];
        int   mt [3];
        int   m;
        int   at;
        logic lv [2];
        logic lr [2];
        logic saw;

        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        req_tag = '0;
        req_data = '0;

        // reset with random inputs
        repeat (3) begin
            @(negedge clk1);
            req_valid = 3'($urandom);
            req_tag   = 9'($urandom);
            req_data  = 48'({$urandom, $urandom});
            #1;
            chk("rst_valid", 32'(cdb_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ready", 32'(req_ready), 7);
        end
        @(negedge clk1);
        rst = 1'b0;
        req_valid = '0;
        chk_on = 1'b1;
        repeat (10) begin
            @(negedge clk1);
            chk("idle_valid", 32'(cdb_valid), 0);
        end

        // single result from the adder
        @(negedge clk1);
        drive(0, 3'd3, 16'h0005);
        @(negedge clk1);
        req_valid = '0;
        chk("single_early", 32'(cdb_valid), 0);
        chk("single_busy", 32'(busy), 1);
        @(negedge clk1);
        chk("single_valid", 32'(cdb_valid), 1);
        chk("single_tag", 32'(cdb_tag), 3);
        chk("single_data", 32'(cdb_data), 5);
        chk("single_src", 32'(cdb_src), 0);
        chk("single_busy_done", 32'(busy), 0);
        @(negedge clk1);
        chk("single_pulse", 32'(cdb_valid), 0);

        // three-way contention from rr_ptr=0
        @(negedge clk1);
        flush = 1'b1;
        @(negedge clk1);
        flush = 1'b0;
        tg = '{1, 2, 4};
        dt = '{10, 20, 30};
        for (int s = 0; s < 3; s++) drive(s, 3'(tg[s]), 16'(dt[s]));
        @(negedge clk1);
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk1);
            chk("rr3_valid", 32'(cdb_valid), 1);
            chk("rr3_src", 32'(cdb_src), k);
            chk("rr3_tag", 32'(cdb_tag), tg[k]);
            chk("rr3_data", 32'(cdb_data), dt[k]);
        end
        @(negedge clk1);
        chk("rr3_end", 32'(cdb_valid), 0);
        chk("rr3_busy", 32'(busy), 0);

        // backpressure: multiplier burst against a streaming adder
        mt = '{5, 6, 7};
        m = 0;
        at = 0;
        lv = '{1'b0, 1'b0};
        lr = '{1'b0, 1'b0};
        saw = 1'b0;
        rec_mul = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk1);
            if (c > 0 && lv[0] && lr[0]) at++;
            if (c > 0 && lv[1] && lr[1]) m++;
            drive(0, 3'(at), 16'(16'h0100 + at));
            if (m < 3) drive(1, 3'(mt[m]), 16'(16'h0200 + m));
            else req_valid[1] = 1'b0;
            lv[0] = req_valid[0];
            lv[1] = req_valid[1];
            lr[0] = req_ready[0];
            lr[1] = req_ready[1];
            if (!req_ready[1]) saw = 1'b1;
        end
        @(negedge clk1);
        if (lv[1] && lr[1]) m++;
        req_valid = '0;
        repeat (8) @(negedge clk1);
        rec_mul = 1'b0;
        chk("bp_mul_full_seen", 32'(saw), 1);
        chk("bp_mul_accepted", m, 3);
        chk("bp_mul_count", mul_seen.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < mul_seen.size())
                chk("bp_mul_order", 32'(mul_seen[i]), mt[i]);

        // flush with queued results and a same-cycle push
        @(negedge clk1);
        for (int s = 0; s < 3; s++) drive(s, 3'(s + 1), 16'(s + 1));
        @(negedge clk1);
        for (int s = 0; s < 3; s++) drive(s, 3'(s + 4), 16'(s + 4));
        @(negedge clk1);
        req_valid = '0;
        drive(0, 3'd6, 16'hDEAD);
        flush = 1'b1;
        @(negedge clk1);
        flush = 1'b0;
        req_valid = '0;
        chk("flush_valid", 32'(cdb_valid), 0);
        chk("flush_busy", 32'(busy), 0);
        chk("flush_ready", 32'(req_ready), 7);
        drive(0, 3'd2, 16'h0042);
        @(negedge clk1);
        req_valid = '0;
        chk("post_flush_early", 32'(cdb_valid), 0);
        @(negedge clk1);
        chk("post_flush_valid", 32'(cdb_valid), 1);
        chk("post_flush_tag", 32'(cdb_tag), 2);
        chk("post_flush_data", 32'(cdb_data), 32'h42);
        chk("post_flush_src", 32'(cdb_src), 0);
        repeat (3) @(negedge clk1);
        chk("flush_dropped", 32'(seen_dead), 0);

        // asynchronous reset while a broadcast is on the bus
        @(negedge clk1);
        drive(0, 3'd1, 16'd7);
        drive(1, 3'd2, 16'd8);
        drive(2, 3'd3, 16'd9);
        @(negedge clk1);
        req_valid = '0;
        @(negedge clk1);
        chk("arst_pre_valid", 32'(cdb_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(cdb_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(req_ready), 7);
        #1 rst = 1'b0;
        @(negedge clk1);
        chk("arst_after_valid", 32'(cdb_valid), 0);
        chk("arst_after_busy", 32'(busy), 0);
        @(negedge clk1);
        chk("arst_after2_valid", 32'(cdb_valid), 0);

        // randomized traffic with occasional flush
        repeat (1500) begin
            @(negedge clk1);
            req_valid = 3'($urandom);
            req_tag   = 9'($urandom);
            req_data  = 48'({$urandom, $urandom});
            flush     = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk1);
        req_valid = '0;
        flush = 1'b0;
        repeat (6) @(negedge clk1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the functional-unit result producers: adder, multiplier and branch unit.
- Each producer pushes {ROB tag, value} into its own small result queue.
- The arbiter grants one queue per cycle in round-robin order and drives a registered broadcast to the ROB and to the add/mul reservation stations for tag matching.
- Flush discards all pending results on branch mispredict.

Parameters:
NSRC, 3, number of result producers (index 0 adder, 1 multiplier, 2 branch)
TAG_W, 3, ROB tag width (8-entry ROB)
DATA_W, 16, result value width
DEPTH, 2, entries per per-source result queue (power of two, >=2)

Ports:
clk1  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous discard of all queued results and in-flight broadcast
req_valid  input  NSRC  per-source result valid
req_tag  input  NSRC*TAG_W  per-source ROB tag, source i at bits [i*TAG_W +: TAG_W]
req_data  input  NSRC*DATA_W  per-source result value, same packing
req_ready  output  NSRC  per-source queue can accept this cycle
cdb_valid  output  1  broadcast valid, one-cycle pulse per result
cdb_tag  output  TAG_W  broadcast ROB tag
cdb_data  output  DATA_W  broadcast value
cdb_src  output  2  index of source whose result is on the bus
busy  output  1  any queue non-empty

Behaviour:
- Reset (async, rst=1): all queues empty, rd/wr pointers 0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, busy=0, req_ready all 1 once rst drops.
- Push: on clk1 edge, if req_valid[i] && req_ready[i] && !flush, write {tag,data} at wr_ptr[i]; wr_ptr wraps modulo DEPTH.
- req_ready[i] = (count[i] < DEPTH), from registered count only. No combinational valid-to-ready path. A full queue does not accept in the same cycle as its pop.
- Push when not ready: ignored. The producer must hold req_valid.
- Arbitration, each cycle:
  - Candidates are the non-empty queues.
  - Search starts at rr_ptr, ascending with wrap. The first non-empty queue wins.
  - The winner's head pops: rd_ptr++ with wrap, count--.
  - rr_ptr <= (winner+1) mod NSRC.
  - No winner: rr_ptr unchanged.
- Output register:
  - On a grant, next cycle cdb_valid=1, cdb_tag/cdb_data = popped entry, cdb_src = winner.
  - With no grant, cdb_valid=0. cdb_tag/data/src hold their last value.
- Latency: result pushed at edge N is broadcast (cdb_valid high) at earliest during cycle N+2. Push edge N, arbitrated in cycle after N, registered at edge N+1.
- Throughput: one broadcast per cycle when any queue is non-empty.
- Fairness: a non-empty queue is granted within NSRC consecutive cycles.
- Simultaneous push and pop on the same queue: count unchanged, both pointers advance.
- count width: clog2(DEPTH)+1. count never exceeds DEPTH and never underflows.
- flush=1 at an edge:
  - All counts and pointers go to 0, rr_ptr=0, cdb_valid=0 next cycle.
  - Same-cycle pushes are dropped; no grant occurs.
  - flush has priority over push and pop.
- rst asserted mid-operation: immediate clear to reset values regardless of clk1; queued data is lost.
- busy = OR of (count[i] != 0), registered state only.

Test Plan:
- Reset: rst=1 with random inputs -> cdb_valid=0, busy=0, req_ready=3'b111. After release with no requests, cdb_valid stays 0 for 10 cycles.
- Single result: adder pushes tag=3, data=16'h0005 at edge N -> cycle N+2 cdb_valid=1, cdb_tag=3, cdb_data=5, cdb_src=0, one cycle only. busy falls after the pop.
- Three-way contention: all sources push at once, tags 1/2/4, data 10/20/30, rr_ptr=0 -> broadcasts on three consecutive cycles in src order 0,1,2, then rr_ptr=0.
- Backpressure: multiplier pushes 3 results back-to-back while the adder streams continuously -> multiplier req_ready drops to 0 when count=2. No result is lost or duplicated. Grants alternate 0,1,0,1. All 3 multiplier tags appear in push order.
- Flush: queue 2 results in each source, assert flush for one cycle while the adder also pushes -> next cycle cdb_valid=0, busy=0. The dropped push never appears. A new push after flush is broadcast with normal latency.
- Async reset mid-stream: assert rst between clk1 edges while cdb_valid=1 -> cdb_valid drops immediately without a clock edge. Queues are empty after release.
